pi_timing_generator: RTL and testbench
======================================

# pi_timing_generator

Generates interlaced PAL-format DPI timing (864 × 625 total, 720 × 576 active) for the Pi-facing video path, as the transmitting counterpart to the Pi pixel-position tracking logic. It produces active-low `hsync` and `vsync`, `display_en`, a pixel clock enable and the current pixel coordinates. Field parity uses the convention the tracker decodes: at the `vsync` falling edge, `hsync` high means an odd field and `hsync` low means an even field. It runs in the 81 MHz domain and advances one pixel per `clk_phase == 0` tick.

## Interface
- `H_SYNC`, 64, hsync low width in pixels
- `H_BP`, 68, horizontal back porch
- `H_ACTIVE`, 720, active pixels per line
- `H_FP`, 12, horizontal front porch (H_TOTAL = 864)
- `V_SYNC`, 3, vsync lines per field
- `V_BP`, 19, vertical back porch lines
- `V_ACTIVE`, 288, active lines per field
- `V_FP`, 2, front porch lines, even field; odd field uses V_FP+1 (field totals 313 odd / 312 even)
- `clk`  in  1  81 MHz clock, single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `clk_phase`  in  3  clock phase; a pixel tick occurs on a `clk` edge where `clk_phase == 0`
- `enable`  in  1  run/idle control, sampled on ticks
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `display_en`  out  1  high during active pixels
- `pixel_ce`  out  1  one-`clk` strobe per active pixel
- `pixel_x`  out  10  active dot, 0–719
- `pixel_y`  out  10  active frame line, 0–575
- `odd_field`  out  1  1 = odd field (first field of frame)
- `field_start`  out  1  one-`clk` strobe when `vsync` falls

## Operation
- Internal counters: `h_cnt` 0..H_TOTAL-1 and `v_cnt` 0..field_total-1, plus a field flag. All update only on tick edges.
- Horizontal line layout, starting from h=0:
  - sync: h 0–63
  - back porch: 64–131
  - active: 132–851
  - front porch: 852–863
- Vertical field layout:
  - sync: lines 0–2
  - back porch: 3–21
  - active: 22–309
  - front porch: 310–311 (even field); 310–312 (odd field)
- Line and field wrap:
  - At h=863, h wraps to 0 and v increments.
  - At the last line of a field, v wraps to 0 and the field flag toggles.
  - Odd field always precedes even field.
- `hsync` = 0 when h < H_SYNC.
- `vsync` edges depend on field:
  - Even field: falls at (v=0, h=0), coincident with the `hsync` fall; rises at (v=3, h=0).
  - Odd field: falls at (v=0, h=432), mid-line with `hsync` high; rises at (v=3, h=432).
- `display_en` = active horizontal region AND active vertical region.
- Coordinates are valid only while `display_en` is high; otherwise they hold their last values.
  - `pixel_x` = h − 132.
  - `pixel_y` = 2·(v − 22) for the odd field, 2·(v − 22) + 1 for the even field.
  - Arithmetic is 10-bit unsigned; no overflow is possible at the default parameters.
- `odd_field` reflects the field of the current output pixel.
- `enable` behaviour:
  - `enable` low at a tick: counters go to h=0, v=0, odd field, and outputs go to their idle/reset values at that same tick.
  - `enable` rising: generation restarts at the start of an odd field.

## Timing
- Reset values: `hsync`=1, `vsync`=1, `display_en`=0, `pixel_ce`=0, `pixel_x`=0, `pixel_y`=0, `odd_field`=1, `field_start`=0. Counters reset to h=0, v=0, odd.
- Reset asserted mid-operation forces these values immediately, independent of `clk`.
- Timing outputs are registered from the pre-increment counter state at each tick edge. They therefore lag the counters by exactly one tick, uniformly across all outputs, so relative timing is exact.
- After reset release, the first tick presents h=0, v=0 of the odd field: `hsync`=0, `vsync`=1.
- `pixel_ce` rises on the tick edge at which `display_en` is registered high. It is high for exactly one `clk` cycle, with coordinates valid in that same cycle.
- `field_start` is high for one `clk` cycle in the cycle `vsync` becomes 0.
- Ticks with `clk_phase ≠ 0` never occur between advances: with `clk_phase` stuck at a nonzero value, all outputs hold and strobes stay 0.
- When a tick coincides with `enable` falling, `enable` takes precedence over the counter advance.

## Test plan
- Reset, then `clk_phase` cycling 0–7 -> one line = 864 ticks (6912 `clk`); `hsync` low for 64 ticks; `display_en` high for 720 contiguous ticks starting 132 ticks after the `hsync` fall.
- Run one full frame -> odd field 313 lines, even field 312 lines, frame = 540000 ticks; `field_start` pulses exactly twice.
- At each `vsync` fall, sample `hsync` -> 1 for the odd field (fall at h=432), 0 for the even field (coincident with the `hsync` fall).
- Coordinate check -> odd-field active lines give `pixel_y` 0, 2, …, 574; even field 1, 3, …, 575; `pixel_x` 0..719 per line; exactly 720 `pixel_ce` per active line and 414720 per frame.
- Assert `reset` mid-active-line, and separately drop `enable` at v=100, h=500 -> outputs at idle values immediately (reset) or at that tick (`enable`); on restart, odd field from h=0, v=0.
- Hold `clk_phase`=3 for 100 `clk` mid-line -> no output change and no strobes; resuming the 0–7 cycle continues from the held position.

Source files
------------

// File: rtl/pi_timing_generator.sv
// PAL-style interlaced DPI timing source (864x625 total, 720x576 active) for the Pi video path.
// Advances one pixel per clk_phase==0 tick; all outputs registered from pre-increment counters.
module pi_timing_generator #(
    parameter int H_SYNC   = 64,
    parameter int H_BP     = 68,
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 12,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 19,
    parameter int V_ACTIVE = 288,
    parameter int V_FP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] clk_phase,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic       pixel_ce,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       odd_field,
    output logic       field_start
);

    localparam logic [9:0] H_SYNC_W    = 10'(H_SYNC);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_HALF      = 10'((H_SYNC + H_BP + H_ACTIVE + H_FP) / 2);
    localparam logic [9:0] V_SYNC_L    = 10'(V_SYNC);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] V_LAST_EVEN = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_LAST_ODD  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);

    logic [9:0] h_cnt, v_cnt;
    logic       odd;

    logic       tick;
    logic       active;
    logic       hs_low, vs_low;
    logic       h_wrap, v_wrap;
    logic [9:0] v_rel;

    always_comb begin
        tick   = (clk_phase == 3'd0);
        active = (h_cnt >= H_START) && (h_cnt < H_END) &&
                 (v_cnt >= V_START) && (v_cnt < V_END);
        hs_low = (h_cnt < H_SYNC_W);
        // Odd field offsets vsync by half a line so hsync is high at the vsync fall.
        if (odd)
            vs_low = ((v_cnt == 10'd0) && (h_cnt >= H_HALF)) ||
                     ((v_cnt != 10'd0) && (v_cnt < V_SYNC_L)) ||
                     ((v_cnt == V_SYNC_L) && (h_cnt < H_HALF));
        else
            vs_low = (v_cnt < V_SYNC_L);
        h_wrap = (h_cnt == H_LAST);
        v_wrap = odd ? (v_cnt == V_LAST_ODD) : (v_cnt == V_LAST_EVEN);
        v_rel  = v_cnt - V_START;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            odd         <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_en  <= 1'b0;
            pixel_ce    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            odd_field   <= 1'b1;
            field_start <= 1'b0;
        end else begin
            pixel_ce    <= 1'b0;
            field_start <= 1'b0;
            if (tick) begin
                if (!enable) begin
                    h_cnt      <= '0;
                    v_cnt      <= '0;
                    odd        <= 1'b1;
                    hsync      <= 1'b1;
                    vsync      <= 1'b1;
                    display_en <= 1'b0;
                    pixel_x    <= '0;
                    pixel_y    <= '0;
                    odd_field  <= 1'b1;
                end else begin
                    hsync       <= ~hs_low;
                    vsync       <= ~vs_low;
                    display_en  <= active;
                    pixel_ce    <= active;
                    odd_field   <= odd;
                    field_start <= vs_low & vsync;
                    if (active) begin
                        pixel_x <= h_cnt - H_START;
                        pixel_y <= {v_rel[8:0], ~odd};
                    end
                    if (h_wrap) begin
                        h_cnt <= '0;
                        if (v_wrap) begin
                            v_cnt <= '0;
                            odd   <= ~odd;
                        end else begin
                            v_cnt <= v_cnt + 10'd1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pi_timing_generator.sv
// Scoreboard bench for pi_timing_generator at a reduced raster so whole frames fit the run.
// Expected outputs come from a frame-position model pushed per clk and popped after each edge.
module tb_pi_timing_generator;

    localparam int HS = 4, HBP = 3, HA = 8, HFP = 3;
    localparam int VS = 3, VBP = 2, VA = 4, VFP = 2;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int HSTART = HS + HBP;
    localparam int VSTART = VS + VBP;
    localparam int EVEN_LINES = VS + VBP + VA + VFP;
    localparam int ODD_LINES = EVEN_LINES + 1;
    localparam int FRAME = (ODD_LINES + EVEN_LINES) * HT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] clk_phase = 3'd0;
    logic       enable = 1'b0;
    logic       hsync, vsync, display_en, pixel_ce, odd_field, field_start;
    logic [9:0] pixel_x, pixel_y;

    pi_timing_generator #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut (
        .clk(clk), .reset(reset), .clk_phase(clk_phase), .enable(enable),
        .hsync(hsync), .vsync(vsync), .display_en(display_en), .pixel_ce(pixel_ce),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .odd_field(odd_field), .field_start(field_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs, vs, de, ce;
        logic [9:0] x, y;
        logic       odd, fs;
    } out_t;

    localparam out_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, ce: 1'b0,
                              x: 10'd0, y: 10'd0, odd: 1'b1, fs: 1'b0};

    out_t exp_q[$];
    out_t ex, got, want;
    int   n, total, bad, ce_cnt, fs_cnt, budget;
    logic [2:0] ph;

    // Position within the frame decides everything; odd vsync window is measured
    // in absolute field pixels starting half a line into line 0.
    function automatic out_t gen(input int k, input out_t prev);
        int p, h, v;
        logic od, vlow;
        out_t r;
        p = k % FRAME;
        od = (p < ODD_LINES * HT);
        if (!od) p = p - ODD_LINES * HT;
        h = p % HT;
        v = p / HT;
        vlow = od ? (p >= HT / 2 && p < VS * HT + HT / 2) : (v < VS);
        r = prev;
        r.hs = (h >= HS);
        r.vs = ~vlow;
        r.de = (h >= HSTART) && (h < HSTART + HA) && (v >= VSTART) && (v < VSTART + VA);
        r.ce = r.de;
        if (r.de) begin
            r.x = 10'(h - HSTART);
            r.y = 10'(2 * (v - VSTART) + (od ? 0 : 1));
        end
        r.odd = od;
        r.fs = vlow && prev.vs;
        return r;
    endfunction

    function automatic out_t sample();
        return '{hs: hsync, vs: vsync, de: display_en, ce: pixel_ce,
                 x: pixel_x, y: pixel_y, odd: odd_field, fs: field_start};
    endfunction

    task automatic step(input logic [2:0] p, input logic e);
        clk_phase = p;
        enable = e;
        if (p == 3'd0) begin
            if (!e) begin
                ex = IDLE;
                n = 0;
            end else begin
                ex = gen(n, ex);
                n++;
            end
        end else begin
            ex.ce = 1'b0;
            ex.fs = 1'b0;
        end
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        got = sample();
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL outputs n=%0d got=%h want=%h", n, got, want);
        end
        if (pixel_ce) ce_cnt++;
        if (field_start) begin
            fs_cnt++;
            total++;
            assert (hsync === odd_field) else begin
                bad++;
                $error("FAIL parity_at_vsync_fall hsync=%b want=%b", hsync, odd_field);
            end
        end
    endtask

    task automatic run(input int nclk, input logic e);
        for (int i = 0; i < nclk; i++) begin
            step(ph, e);
            ph = ph + 3'd1;
        end
    endtask

    task automatic run_to(input int pos);
        budget = 8 * FRAME + 16;
        while (!(ph == 3'd0 && (n % FRAME) == pos) && budget > 0) begin
            step(ph, 1'b1);
            ph = ph + 3'd1;
            budget--;
        end
        total++;
        assert (budget > 0) else begin
            bad++;
            $error("FAIL run_to_timeout pos=%0d got=%0d want=%0d", pos, n % FRAME, pos);
        end
    endtask

    task automatic check_idle(input string tag);
        got = sample();
        total++;
        assert (got === IDLE) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, IDLE);
        end
    endtask

    initial begin
        total = 0; bad = 0; n = 0; ph = 3'd0; ce_cnt = 0; fs_cnt = 0;
        ex = IDLE;
        #12;
        check_idle("reset_values");
        reset = 1'b0;

        // One full frame with the phase cycling 0..7.
        run(FRAME * 8, 1'b1);
        total++;
        assert (ce_cnt === 2 * VA * HA) else begin
            bad++;
            $error("FAIL ce_per_frame got=%0d want=%0d", ce_cnt, 2 * VA * HA);
        end
        total++;
        assert (fs_cnt === 2) else begin
            bad++;
            $error("FAIL field_start_per_frame got=%0d want=%0d", fs_cnt, 2);
        end

        // Stall the phase mid-line; outputs must hold with no strobes.
        run_to(VSTART * HT + HSTART + 2);
        for (int i = 0; i < 100; i++) step(3'd3, 1'b1);
        run(HT * 8 * 2, 1'b1);

        // Drop enable on an active pixel of the even field, then restart.
        run_to(ODD_LINES * HT + (VSTART + 1) * HT + HSTART + 3);
        step(3'd0, 1'b0);
        ph = 3'd1;
        check_idle("enable_drop_idle");
        run(20, 1'b0);
        run(HT * 8 * 3, 1'b1);

        // Async reset mid active line: idle immediately, before any clk edge.
        run_to(VSTART * HT + HSTART + 3);
        step(ph, 1'b1);
        ph = ph + 3'd1;
        #2 reset = 1'b1;
        #1 check_idle("async_reset_now");
        @(posedge clk);
        #1 check_idle("async_reset_held");
        #1 reset = 1'b0;
        ex = IDLE;
        n = 0;
        run(FRAME * 4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
